// File: rtl/lb_pkg.sv
// Shared constants and helpers for the multi-line buffer bank.
// Used by the line stores and the control/output logic in line_buf_bank.
package lb_pkg;

    localparam int MAX_W_DEF  = 1280;
    localparam int DW_DEF     = 8;
    localparam int NLINES_MAX = 4;
    localparam int FILL_W     = $clog2(NLINES_MAX + 1);

    // LSB position of tap k inside the packed output bus.
    function automatic int tap_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/lb_ram.sv
// Simple dual-port line store: one write port, one registered read port.
// Contents are deliberately not reset; the read register holds while re is low.
module lb_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 1280,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buf_bank.sv
// Multi-line buffer: presents each accepted pixel together with the co-located
// pixels of the NLINES previous lines, one cycle after acceptance.
module line_buf_bank
    import lb_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int MAX_W  = MAX_W_DEF,
    parameter int NLINES = 2,
    localparam int AW    = $clog2(MAX_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sof,
    input  logic [AW:0]              line_len,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    output logic [DW*(NLINES+1)-1:0] out_data,
    output logic [NLINES:0]          out_tap_vld,
    output logic [AW-1:0]            out_col,
    output logic                     out_eol,
    output logic                     frame_err
);

    localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_W);
    localparam logic [AW:0] MIN_LEN = (AW+1)'(2);

    logic [AW-1:0]            col, col_eff, col_nxt, col_d;
    logic [FILL_W-1:0]        fill, fill_eff, fill_nxt;
    logic [AW:0]              len_q, len_eff, len_clamped;
    logic                     is_last;
    logic                     seen_sof;
    logic                     v_d, eol_d, frame_err_q;
    logic [DW-1:0]            data_d;
    logic [NLINES:0]          tvld_nxt, tvld_d;
    logic [NLINES:0][DW-1:0]  tap_src;

    always_comb begin
        len_clamped = line_len;
        if (line_len < MIN_LEN) begin
            len_clamped = MIN_LEN;
        end else if (line_len > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end
    end

    // A sof pixel is column 0 of a fresh frame, so it overrides any wrap
    // that the old column count would have produced in the same cycle.
    always_comb begin
        col_eff  = col;
        fill_eff = fill;
        len_eff  = len_q;
        if (sof) begin
            col_eff  = '0;
            fill_eff = '0;
            len_eff  = len_clamped;
        end
        is_last  = ({1'b0, col_eff} == (len_eff - (AW+1)'(1)));
        col_nxt  = is_last ? '0 : (col_eff + AW'(1));
        fill_nxt = fill_eff;
        if (is_last && (int'(fill_eff) < NLINES)) begin
            fill_nxt = fill_eff + FILL_W'(1);
        end
        for (int k = 0; k <= NLINES; k++) begin
            tvld_nxt[k] = (int'(fill_eff) >= k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            fill        <= '0;
            len_q       <= MAX_LEN;
            seen_sof    <= 1'b0;
            v_d         <= 1'b0;
            col_d       <= '0;
            data_d      <= '0;
            eol_d       <= 1'b0;
            tvld_d      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            v_d <= in_valid;
            if (in_valid) begin
                col    <= col_nxt;
                fill   <= fill_nxt;
                col_d  <= col_eff;
                data_d <= in_data;
                eol_d  <= is_last;
                tvld_d <= tvld_nxt;
                if (sof) begin
                    len_q       <= len_clamped;
                    seen_sof    <= 1'b1;
                    frame_err_q <= 1'b0;
                end else if (!seen_sof) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    assign tap_src[0] = data_d;

    // Store k is written one cycle after acceptance with what store k-1 held
    // at that column, so the lines ripple down the chain as they age.
    for (genvar k = 1; k <= NLINES; k++) begin : g_store
        lb_ram #(
            .DW    (DW),
            .DEPTH (MAX_W)
        ) u_ram (
            .clk   (clk),
            .we    (v_d),
            .waddr (col_d),
            .wdata (tap_src[k-1]),
            .re    (in_valid),
            .raddr (col_eff),
            .rdata (tap_src[k])
        );
    end

    for (genvar k = 0; k <= NLINES; k++) begin : g_tap
        assign out_data[tap_lsb(k, DW) +: DW] = tvld_d[k] ? tap_src[k] : '0;
    end

    assign out_valid   = v_d;
    assign out_tap_vld = tvld_d;
    assign out_col     = col_d;
    assign out_eol     = eol_d;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_line_buf_bank.sv
// Directed self-checking bench for line_buf_bank: a 2-line instance for most
// scenarios plus a 4-line instance for the full-width fill check.
module tb_line_buf_bank;

    localparam int DW = 8;
    localparam int MAX_W = 1280;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW:0]   line_len = '0;
    logic [DW-1:0] in_data = '0;

    logic          out_valid_a, out_eol_a, frame_err_a;
    logic [23:0]   out_data_a;
    logic [2:0]    out_tap_vld_a;
    logic [AW-1:0] out_col_a;

    logic          out_valid_b, out_eol_b, frame_err_b;
    logic [39:0]   out_data_b;
    logic [4:0]    out_tap_vld_b;
    logic [AW-1:0] out_col_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_buf_bank #(.DW(DW), .MAX_W(MAX_W), .NLINES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .sof(sof), .line_len(line_len),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_tap_vld(out_tap_vld_a),
        .out_col(out_col_a), .out_eol(out_eol_a), .frame_err(frame_err_a)
    );

    line_buf_bank #(.DW(DW), .MAX_W(MAX_W), .NLINES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .sof(sof), .line_len(line_len),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_tap_vld(out_tap_vld_b),
        .out_col(out_col_b), .out_eol(out_eol_b), .frame_err(frame_err_b)
    );

    // Inputs change right after an edge; outputs for that pixel are stable 1ns after the next edge.
    task automatic drive(input logic s, input logic v, input logic [DW-1:0] d);
        sof = s;
        in_valid = v;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ramp_exp(input int r, input int c, input int base);
        logic [23:0] e;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            if (r - k >= 0) e[8*k +: 8] = 8'(base + 10*(r-k) + c);
        end
        return e;
    endfunction

    function automatic logic [2:0] vld_exp(input int r);
        return (r >= 2) ? 3'b111 : ((r == 1) ? 3'b011 : 3'b001);
    endfunction

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r*37 + c);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid_a, out_data_a, out_tap_vld_a, out_col_a, out_eol_a, frame_err_a} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_a: got v=%b d=%h vld=%b col=%0d eol=%b ferr=%b, want all 0",
                     out_valid_a, out_data_a, out_tap_vld_a, out_col_a, out_eol_a, frame_err_a);
        end
        checks++;
        if ({out_valid_b, out_data_b, out_tap_vld_b, out_col_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_b: got v=%b d=%h vld=%b col=%0d, want all 0",
                     out_valid_b, out_data_b, out_tap_vld_b, out_col_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_ramp();
        line_len = 12'd4;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(r == 0 && c == 0, 1'b1, 8'(10*r + c));
                checks++;
                if ({out_valid_a, out_col_a, out_eol_a, out_tap_vld_a, out_data_a} !==
                    {1'b1, 11'(c), 1'(c == 3), vld_exp(r), ramp_exp(r, c, 0)}) begin
                    errors++;
                    $display("[TB] FAIL ramp r%0d c%0d: got v=%b col=%0d eol=%b vld=%b d=%h, want col=%0d vld=%b d=%h",
                             r, c, out_valid_a, out_col_a, out_eol_a, out_tap_vld_a, out_data_a,
                             c, vld_exp(r), ramp_exp(r, c, 0));
                end
                if (r == 2 && c == 3) begin
                    checks++;
                    if (out_data_a !== 24'h030D17) begin
                        errors++;
                        $display("[TB] FAIL ramp_r2c3: got %h, want 030d17", out_data_a);
                    end
                end
                if (r == 1) begin
                    checks++;
                    if (out_data_a[23:16] !== 8'd0) begin
                        errors++;
                        $display("[TB] FAIL ramp_r1_tap2: got %h, want 00", out_data_a[23:16]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        // sof pixel directly after the previous eol pixel
        drive(1'b1, 1'b1, 8'd200);
        checks++;
        if ({out_valid_a, out_col_a, out_tap_vld_a, out_data_a} !== {1'b1, 11'd0, 3'b001, 24'h0000C8}) begin
            errors++;
            $display("[TB] FAIL b2b_sof: got v=%b col=%0d vld=%b d=%h, want col=0 vld=001 d=0000c8",
                     out_valid_a, out_col_a, out_tap_vld_a, out_data_a);
        end
        drive(1'b0, 1'b1, 8'd201);
        drive(1'b0, 1'b1, 8'd202);
        // sof lands where the wrap would have happened
        drive(1'b1, 1'b1, 8'd210);
        checks++;
        if ({out_col_a, out_eol_a, out_tap_vld_a} !== {11'd0, 1'b0, 3'b001}) begin
            errors++;
            $display("[TB] FAIL b2b_sof_at_wrap: got col=%0d eol=%b vld=%b, want col=0 eol=0 vld=001",
                     out_col_a, out_eol_a, out_tap_vld_a);
        end
        drive(1'b0, 1'b1, 8'd211);
        checks++;
        if ({out_col_a, out_eol_a} !== {11'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_after: got col=%0d eol=%b, want col=1 eol=0", out_col_a, out_eol_a);
        end
    endtask

    task automatic test_random_stalls();
        int gaps;
        line_len = 12'd4;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                gaps = 0;
                while (gaps < 4 && $urandom_range(0, 1) == 1) begin
                    drive(1'b0, 1'b0, 8'hEE);
                    gaps++;
                    checks++;
                    if (out_valid_a !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL stall_idle r%0d c%0d: got out_valid=%b, want 0", r, c, out_valid_a);
                    end
                end
                drive(r == 0 && c == 0, 1'b1, 8'(10*r + c));
                checks++;
                if ({out_valid_a, out_col_a, out_eol_a, out_tap_vld_a, out_data_a} !==
                    {1'b1, 11'(c), 1'(c == 3), vld_exp(r), ramp_exp(r, c, 0)}) begin
                    errors++;
                    $display("[TB] FAIL stall r%0d c%0d: got v=%b col=%0d eol=%b vld=%b d=%h, want col=%0d vld=%b d=%h",
                             r, c, out_valid_a, out_col_a, out_eol_a, out_tap_vld_a, out_data_a,
                             c, vld_exp(r), ramp_exp(r, c, 0));
                end
            end
        end
    endtask

    task automatic test_frame_restart();
        line_len = 12'd4;
        for (int c = 0; c < 4; c++) drive(c == 0, 1'b1, 8'(50 + c));
        drive(1'b0, 1'b1, 8'd60);
        drive(1'b0, 1'b1, 8'd61);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(r == 0 && c == 0, 1'b1, 8'(100 + 10*r + c));
                checks++;
                if ({out_col_a, out_tap_vld_a, out_data_a} !== {11'(c), vld_exp(r), ramp_exp(r, c, 100)}) begin
                    errors++;
                    $display("[TB] FAIL restart r%0d c%0d: got col=%0d vld=%b d=%h, want col=%0d vld=%b d=%h",
                             r, c, out_col_a, out_tap_vld_a, out_data_a, c, vld_exp(r), ramp_exp(r, c, 100));
                end
            end
        end
    endtask

    task automatic test_length_clamp();
        int bad;
        line_len = 12'd0;
        drive(1'b1, 1'b1, 8'd1);
        drive(1'b0, 1'b1, 8'd2);
        checks++;
        if ({out_col_a, out_eol_a} !== {11'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL clamp0_eol: got col=%0d eol=%b, want col=1 eol=1", out_col_a, out_eol_a);
        end
        drive(1'b0, 1'b1, 8'd3);
        checks++;
        if ({out_col_a, out_eol_a} !== {11'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clamp0_wrap: got col=%0d eol=%b, want col=0 eol=0", out_col_a, out_eol_a);
        end
        line_len = 12'd2000;
        bad = 0;
        for (int c = 0; c < MAX_W; c++) begin
            drive(c == 0, 1'b1, 8'(c));
            if (c == 0) line_len = 12'd3;
            if ((out_col_a !== 11'(c)) || (out_eol_a !== 1'(c == MAX_W - 1))) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL clamp2000_line: got %0d bad col/eol pixels, want 0", bad);
        end
        checks++;
        if ({out_col_a, out_eol_a} !== {11'd1279, 1'b1}) begin
            errors++;
            $display("[TB] FAIL clamp2000_eol: got col=%0d eol=%b, want col=1279 eol=1", out_col_a, out_eol_a);
        end
        drive(1'b0, 1'b1, 8'd9);
        checks++;
        if ({out_col_a, out_eol_a} !== {11'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clamp2000_wrap: got col=%0d eol=%b, want col=0 eol=0", out_col_a, out_eol_a);
        end
    endtask

    task automatic test_full_width();
        logic [4:0] vexp;
        line_len = 12'd1280;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < MAX_W; c++) begin
                drive(r == 0 && c == 0, 1'b1, pix(r, c));
                if (c == MAX_W - 1) begin
                    vexp = (r >= 4) ? 5'b11111 : 5'((1 << (r + 1)) - 1);
                    checks++;
                    if ({out_tap_vld_b, out_eol_b, out_col_b} !== {vexp, 1'b1, 11'd1279}) begin
                        errors++;
                        $display("[TB] FAIL full_row%0d: got vld=%b eol=%b col=%0d, want vld=%b eol=1 col=1279",
                                 r, out_tap_vld_b, out_eol_b, out_col_b, vexp);
                    end
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_data_b[8*k +: 8] !== pix(5 - k, MAX_W - 1)) begin
                errors++;
                $display("[TB] FAIL full_tap%0d: got %h, want %h", k, out_data_b[8*k +: 8], pix(5 - k, MAX_W - 1));
            end
        end
        checks++;
        if (out_data_a !== {pix(3, 1279), pix(4, 1279), pix(5, 1279)}) begin
            errors++;
            $display("[TB] FAIL full_taps_a: got %h, want %h", out_data_a, {pix(3, 1279), pix(4, 1279), pix(5, 1279)});
        end
    endtask

    task automatic test_mid_reset();
        line_len = 12'd4;
        for (int c = 0; c < 4; c++) drive(c == 0, 1'b1, 8'(c));
        drive(1'b0, 1'b1, 8'd10);
        drive(1'b0, 1'b1, 8'd11);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid_a, out_data_a, out_tap_vld_a, out_col_a, out_eol_a, frame_err_a} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got v=%b d=%h vld=%b col=%0d eol=%b ferr=%b, want all 0",
                     out_valid_a, out_data_a, out_tap_vld_a, out_col_a, out_eol_a, frame_err_a);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'd77);
        checks++;
        if ({out_valid_a, out_col_a, frame_err_a, out_tap_vld_a} !== {1'b1, 11'd0, 1'b1, 3'b001}) begin
            errors++;
            $display("[TB] FAIL nosof_err: got v=%b col=%0d ferr=%b vld=%b, want v=1 col=0 ferr=1 vld=001",
                     out_valid_a, out_col_a, frame_err_a, out_tap_vld_a);
        end
        drive(1'b0, 1'b1, 8'd78);
        checks++;
        if ({out_col_a, out_eol_a, frame_err_a} !== {11'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL nosof_sticky: got col=%0d eol=%b ferr=%b, want col=1 eol=0 ferr=1",
                     out_col_a, out_eol_a, frame_err_a);
        end
        drive(1'b1, 1'b1, 8'd79);
        checks++;
        if ({out_col_a, frame_err_a, out_tap_vld_a} !== {11'd0, 1'b0, 3'b001}) begin
            errors++;
            $display("[TB] FAIL sof_clears_err: got col=%0d ferr=%b vld=%b, want col=0 ferr=0 vld=001",
                     out_col_a, frame_err_a, out_tap_vld_a);
        end
    endtask

    initial begin
        test_reset();
        test_fill_ramp();
        test_back_to_back();
        test_random_stalls();
        test_frame_restart();
        test_length_clamp();
        test_full_width();
        test_mid_reset();
        drive(1'b0, 1'b0, 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
